// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
//   start, A, B, BIN : request side, driven by the controller (master)
//   Diff, Bout, Ovf  : result side, driven by the subtractor (slave)
//   busy, done       : status, driven by the subtractor (slave)
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, BIN,
        input  Diff, Bout, Ovf, busy, done
    );

    modport slave (
        input  start, A, B, BIN,
        output Diff, Bout, Ovf, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - BIN, one bit per clock, LSB first.
// A single borrow flip-flop carries state between bit steps.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_if
//           (start/A/B/BIN in; Diff/Bout/Ovf/busy/done out, all registered)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Current bit-slice of the full subtractor
    logic a_bit, b_bit, d_bit, borrow_nxt;

    assign a_bit      = a_q[0];
    assign b_bit      = b_q[0];
    assign d_bit      = a_bit ^ b_bit ^ borrow_q;
    assign borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // Results are left untouched here; they hold until overwritten
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = bus.BIN;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                diff_d   = {d_bit, diff_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // On the last step a_bit/b_bit are the original operand MSBs
                    bout_d  = borrow_nxt;
                    ovf_d   = (a_bit != b_bit) && (d_bit != a_bit);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.Ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request at a negedge; return edges from accept edge to done (-1 on timeout)
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.BIN   = bin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.BIN   = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.Diff !== 8'h00) begin n_err++; $display("FAIL reset_diff got %h exp 00", bus.Diff); end
        n_vec++; if (bus.Bout !== 1'b0)  begin n_err++; $display("FAIL reset_bout got %b exp 0", bus.Bout); end
        n_vec++; if (bus.Ovf  !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got %b exp 0", bus.Ovf); end
        n_vec++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0)  begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_arith();
        // {A, B, BIN, Diff, Bout, Ovf}, hand-computed
        logic [W-1:0] va [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF};
        logic [W-1:0] vb [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF};
        logic         vi [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        logic [W-1:0] vd [6] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hFF, 8'h00};
        logic         vbo[6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        logic         vo [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vi[i], lat);
            n_vec++; if (lat !== 8) begin n_err++; $display("FAIL arith%0d_latency got %0d exp 8", i, lat); end
            n_vec++; if (bus.Diff !== vd[i]) begin n_err++; $display("FAIL arith%0d_diff got %h exp %h", i, bus.Diff, vd[i]); end
            n_vec++; if (bus.Bout !== vbo[i]) begin n_err++; $display("FAIL arith%0d_bout got %b exp %b", i, bus.Bout, vbo[i]); end
            n_vec++; if (bus.Ovf !== vo[i]) begin n_err++; $display("FAIL arith%0d_ovf got %b exp %b", i, bus.Ovf, vo[i]); end
            @(negedge clk);
            n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL arith%0d_done_pulse got %b exp 0", i, bus.done); end
            // Results must hold in IDLE
            repeat (3) @(negedge clk);
            n_vec++; if (bus.Diff !== vd[i]) begin n_err++; $display("FAIL arith%0d_hold got %h exp %h", i, bus.Diff, vd[i]); end
            n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arith%0d_idle_busy got %b exp 0", i, bus.busy); end
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [W-1:0] d_at_done = '0;
        logic         b_at_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h10;
        bus.B     = 8'h01;
        bus.BIN   = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (i == 1) begin
                bus.start = 1'b1;
                bus.A     = 8'h55;
                bus.B     = 8'h22;
                bus.BIN   = 1'b1;
            end
            if (i == 4) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                d_at_done = bus.Diff;
                b_at_done = bus.Bout;
            end
        end
        n_vec++; if (busy_cnt !== 9) begin n_err++; $display("FAIL b2b_busy_cycles got %0d exp 9", busy_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done_pulses got %0d exp 1", done_cnt); end
        n_vec++; if (d_at_done !== 8'h0F) begin n_err++; $display("FAIL b2b_diff got %h exp 0f", d_at_done); end
        n_vec++; if (b_at_done !== 1'b0) begin n_err++; $display("FAIL b2b_bout got %b exp 0", b_at_done); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h40;
        bus.B     = 8'h10;
        bus.BIN   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.Diff !== 8'h00) begin n_err++; $display("FAIL abort_diff got %h exp 00", bus.Diff); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        n_vec++; if ({bus.Bout, bus.Ovf, bus.done} !== 3'b000) begin
            n_err++; $display("FAIL abort_flags got %b exp 000", {bus.Bout, bus.Ovf, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
        run_op(8'h09, 8'h04, 1'b0, lat);
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL restart_latency got %0d exp 8", lat); end
        n_vec++; if (bus.Diff !== 8'h05) begin n_err++; $display("FAIL restart_diff got %h exp 05", bus.Diff); end
        n_vec++; if (bus.Bout !== 1'b0) begin n_err++; $display("FAIL restart_bout got %b exp 0", bus.Bout); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
